cmt_sumcheck_sequencer: RTL and testbench
=========================================

Name: cmt_sumcheck_sequencer

Overview:
- Control FSM that orders the prover side of the CMT sumcheck exchange with the verifier link, one computation at a time.
- Per computation: request Q0; then for each layer run NROUNDS rounds of (compute F012 -> send F012 -> receive R); then compute H -> send H -> receive Qi for the next layer.
- Moves control and command tags only. Field data (F012, H, R, Q) travels on datapath buses that this block's strobes select and load.
- Sits between the per-layer sumcheck engine and the VPI/network verifier interface.

Parameters:
- NLAYERS, 3, number of circuit layers (at least 1).
- NROUNDS, 8, sumcheck rounds per layer (at least 1).
- LBITS, 4, width of the layer index (must satisfy 2^LBITS >= NLAYERS).
- RBITS, 4, width of the round index (must satisfy 2^RBITS >= NROUNDS).
- CBITS, 4, width of a command code; encodings are the `CMT_* defines in verifier_interface_defs.v.

Ports:
- clk, in, 1, clock.
- rstb, in, 1, synchronous reset, active low.
- start, in, 1, begin a computation; sampled only in IDLE.
- abort, in, 1, return to IDLE next cycle from any state.
- eng_go, out, 1, one-cycle pulse that starts the engine on the current layer/round (F012 or H).
- eng_is_h, out, 1, qualifies eng_go: 1 = compute H, 0 = compute F012.
- eng_done, in, 1, engine result is ready on the datapath.
- tx_valid, out, 1, send request to the link.
- tx_ready, in, 1, link accepts the send.
- tx_cmd, out, CBITS, `CMT_F012 or `CMT_H.
- rx_req, out, 1, request a value from the link.
- rx_cmd, out, CBITS, `CMT_Q0, `CMT_R or `CMT_QI.
- rx_valid, in, 1, link returns the requested value.
- rx_load, out, 1, one-cycle strobe that loads the returned value into the datapath register selected by rx_cmd.
- layer, out, LBITS, current layer index.
- round, out, RBITS, current round index.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse when a computation completes.
- err, out, 1, sticky protocol-error flag.

Behaviour:
- Reset (rstb=0 at a clk edge):
  - state=IDLE; layer=0; round=0; err=0.
  - All strobes (eng_go, eng_is_h, tx_valid, rx_req, rx_load, done) = 0; busy=0.
  - tx_cmd and rx_cmd = 0.
  - Reset asserted mid-operation discards all progress, including any pending tx/rx.
- States: IDLE, GET_Q0, COMPUTE, SEND, GET_R, GET_QI, FINISH.
- IDLE:
  - start=1 -> GET_Q0, with layer=0, round=0 and err cleared.
- GET_Q0:
  - rx_req=1, rx_cmd=`CMT_Q0.
  - On rx_valid: rx_load=1 in the same cycle; state -> COMPUTE with eng_is_h=0.
- COMPUTE:
  - eng_go pulses exactly in the first cycle of the state; the engine reads eng_is_h alongside it.
  - Wait for eng_done, then -> SEND.
  - eng_done in the entry cycle is legal: it moves to SEND next cycle.
- SEND:
  - tx_valid=1; tx_cmd=`CMT_H if eng_is_h else `CMT_F012.
  - tx_valid and tx_cmd stay stable until tx_ready; the transfer happens in the cycle where both are 1.
  - After an F012 transfer -> GET_R.
  - After an H transfer:
    - if layer==NLAYERS-1 -> FINISH;
    - otherwise -> GET_QI.
- GET_R:
  - rx_req=1, rx_cmd=`CMT_R.
  - On rx_valid: rx_load=1.
  - If round==NROUNDS-1: round stays, eng_is_h=1, -> COMPUTE.
  - Otherwise: round+1, -> COMPUTE with eng_is_h=0.
- GET_QI:
  - rx_req=1, rx_cmd=`CMT_QI.
  - layer output already shows layer+1 during this request; Qi is the claim for the next layer.
  - On rx_valid: rx_load=1, round=0, eng_is_h=0, -> COMPUTE.
  - The layer increment happens on the H transfer cycle.
- FINISH:
  - done=1 for one cycle, then -> IDLE.
  - layer and round hold their final values until the next start.
- Protocol errors (all set err=1, go to IDLE, and err stays 1 until the next accepted start or reset):
  - rx_valid while rx_req=0;
  - eng_done outside COMPUTE.
- abort:
  - Highest priority after reset. Next state is IDLE and all strobes drop.
  - err is not set; no done pulse is produced.
- start while busy is ignored.
- Index ranges: the round counter never exceeds NROUNDS-1; the layer counter never exceeds NLAYERS-1.
- Totals per computation:
  - NLAYERS*NROUNDS F012 sends and NLAYERS H sends;
  - 1 Q0, NLAYERS*NROUNDS R and NLAYERS-1 Qi receives.

Test Plan:
- Nominal, NLAYERS=3, NROUNDS=8, link and engine answer in 1 cycle -> tx sequence is 8xF012 then H, repeated for layers 0,1,2; rx sequence is Q0, 8xR, Qi, 8xR, Qi, 8xR; exactly one done; totals 24 F012, 3 H, 24 R, 2 Qi.
- Backpressure: tx_ready held low for 5 cycles on layer 1 round 3 -> tx_valid and tx_cmd=`CMT_F012 stay stable all 5 cycles, round=3 stays stable, exactly one transfer occurs.
- Last-round boundary: capture the rx_valid at layer 0 round 7 -> the next eng_go has eng_is_h=1 and round=7; after the H transfer, layer=1 and rx_cmd=`CMT_QI.
- Spurious rx_valid while in COMPUTE -> err=1 next cycle, state IDLE, busy=0; err clears on the next start.
- abort during GET_R at layer 2 round 4 -> busy=0 next cycle, no done pulse, err=0; a new start then restarts from GET_Q0 with layer=0 and round=0.
- rstb low mid-SEND -> tx_valid=0 on the next edge; all outputs at their reset values.

Source files
------------

// File: rtl/cmt_sumcheck_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cmt_sumcheck_sequencer
// Brief   : Prover-side control FSM ordering CMT sumcheck rounds with the verifier link.
// Revision: 1.0
// ============================================================================
module cmt_sumcheck_sequencer #(
  parameter int NLAYERS = 3,
  parameter int NROUNDS = 8,
  parameter int LBITS   = 4,
  parameter int RBITS   = 4,
  parameter int CBITS   = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  output logic             eng_go,
  output logic             eng_is_h,
  input  logic             eng_done,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CBITS-1:0] tx_cmd,
  output logic             rx_req,
  output logic [CBITS-1:0] rx_cmd,
  input  logic             rx_valid,
  output logic             rx_load,
  output logic [LBITS-1:0] layer,
  output logic [RBITS-1:0] round,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Command codes mirror the CMT_* encodings of verifier_interface_defs.v.
  localparam logic [CBITS-1:0] c_CMD_F012 = CBITS'(1);
  localparam logic [CBITS-1:0] c_CMD_H    = CBITS'(2);
  localparam logic [CBITS-1:0] c_CMD_Q0   = CBITS'(3);
  localparam logic [CBITS-1:0] c_CMD_R    = CBITS'(4);
  localparam logic [CBITS-1:0] c_CMD_QI   = CBITS'(5);

  localparam logic [LBITS-1:0] c_LAST_LAYER = LBITS'(NLAYERS - 1);
  localparam logic [RBITS-1:0] c_LAST_ROUND = RBITS'(NROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_Q0  = 3'd1,
    S_COMPUTE = 3'd2,
    S_SEND    = 3'd3,
    S_GET_R   = 3'd4,
    S_GET_QI  = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t           r_state;
  logic [LBITS-1:0] r_layer;
  logic [RBITS-1:0] r_round;
  logic             r_eng_go;
  logic             r_eng_is_h;
  logic             r_tx_valid;
  logic [CBITS-1:0] r_tx_cmd;
  logic             r_rx_req;
  logic [CBITS-1:0] r_rx_cmd;
  logic             r_done;
  logic             r_err;

  logic w_proto_err;

  assign w_proto_err = (rx_valid && !r_rx_req) || (eng_done && (r_state != S_COMPUTE));

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state    <= S_IDLE;
      r_layer    <= '0;
      r_round    <= '0;
      r_eng_go   <= 1'b0;
      r_eng_is_h <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_cmd   <= '0;
      r_rx_req   <= 1'b0;
      r_rx_cmd   <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_eng_go <= 1'b0;
      r_done   <= 1'b0;
      if (abort || w_proto_err) begin
        // Abort wins over a protocol error in the same cycle and leaves err alone.
        r_state    <= S_IDLE;
        r_eng_is_h <= 1'b0;
        r_tx_valid <= 1'b0;
        r_tx_cmd   <= '0;
        r_rx_req   <= 1'b0;
        r_rx_cmd   <= '0;
        if (!abort) r_err <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state  <= S_GET_Q0;
              r_layer  <= '0;
              r_round  <= '0;
              r_err    <= 1'b0;
              r_rx_req <= 1'b1;
              r_rx_cmd <= c_CMD_Q0;
            end
          end
          S_GET_Q0: begin
            if (rx_valid) begin
              r_state    <= S_COMPUTE;
              r_rx_req   <= 1'b0;
              r_rx_cmd   <= '0;
              r_eng_is_h <= 1'b0;
              r_eng_go   <= 1'b1;
            end
          end
          S_COMPUTE: begin
            if (eng_done) begin
              r_state    <= S_SEND;
              r_tx_valid <= 1'b1;
              r_tx_cmd   <= r_eng_is_h ? c_CMD_H : c_CMD_F012;
            end
          end
          S_SEND: begin
            if (tx_ready) begin
              r_tx_valid <= 1'b0;
              r_tx_cmd   <= '0;
              if (!r_eng_is_h) begin
                r_state  <= S_GET_R;
                r_rx_req <= 1'b1;
                r_rx_cmd <= c_CMD_R;
              end else if (r_layer == c_LAST_LAYER) begin
                r_state    <= S_FINISH;
                r_done     <= 1'b1;
                r_eng_is_h <= 1'b0;
              end else begin
                // Layer advances here so the Qi request already names the next layer.
                r_state  <= S_GET_QI;
                r_layer  <= r_layer + LBITS'(1);
                r_rx_req <= 1'b1;
                r_rx_cmd <= c_CMD_QI;
              end
            end
          end
          S_GET_R: begin
            if (rx_valid) begin
              r_state  <= S_COMPUTE;
              r_rx_req <= 1'b0;
              r_rx_cmd <= '0;
              r_eng_go <= 1'b1;
              if (r_round == c_LAST_ROUND) begin
                r_eng_is_h <= 1'b1;
              end else begin
                r_round    <= r_round + RBITS'(1);
                r_eng_is_h <= 1'b0;
              end
            end
          end
          S_GET_QI: begin
            if (rx_valid) begin
              r_state    <= S_COMPUTE;
              r_rx_req   <= 1'b0;
              r_rx_cmd   <= '0;
              r_round    <= '0;
              r_eng_is_h <= 1'b0;
              r_eng_go   <= 1'b1;
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign eng_go   = r_eng_go;
  assign eng_is_h = r_eng_is_h;
  assign tx_valid = r_tx_valid;
  assign tx_cmd   = r_tx_cmd;
  assign rx_req   = r_rx_req;
  assign rx_cmd   = r_rx_cmd;
  assign rx_load  = r_rx_req && rx_valid;
  assign layer    = r_layer;
  assign round    = r_round;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmt_sumcheck_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cmt_sumcheck_sequencer
// Brief   : Randomized scoreboard bench for cmt_sumcheck_sequencer.
// Revision: 1.0
// ============================================================================
module tb_cmt_sumcheck_sequencer;
  localparam int NL = 3;
  localparam int NR = 8;
  localparam logic [3:0] F012 = 4'd1, H = 4'd2, Q0 = 4'd3, R = 4'd4, QI = 4'd5;

  logic clk = 1'b0, rstb = 1'b0, start = 1'b0, abort = 1'b0;
  logic eng_done = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic eng_go, eng_is_h, tx_valid, rx_req, rx_load, busy, done, err;
  logic [3:0] tx_cmd, rx_cmd, layer, round;

  cmt_sumcheck_sequencer #(.NLAYERS(NL), .NROUNDS(NR), .LBITS(4), .RBITS(4), .CBITS(4)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .eng_go(eng_go), .eng_is_h(eng_is_h), .eng_done(eng_done),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_cmd(tx_cmd),
    .rx_req(rx_req), .rx_cmd(rx_cmd), .rx_valid(rx_valid), .rx_load(rx_load),
    .layer(layer), .round(round), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct { logic [3:0] cmd; int lyr; int rnd; } ev_t;
  ev_t txq[$], rxq[$], engq[$];

  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, cnt_f012 = 0, cnt_h = 0, cnt_r = 0, cnt_qi = 0;
  bit auto_drv = 0, fast = 0, sb_en = 1;
  bit bp_arm = 0, abort_arm = 0, abort_hit = 0, rst_arm = 0, rst_hit = 0;
  int bp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: the full exchange of one computation as ordered event lists.
  task automatic push_expected();
    rxq.push_back('{Q0, 0, 0});
    for (int l = 0; l < NL; l++) begin
      for (int r = 0; r < NR; r++) begin
        engq.push_back('{4'd0, l, r});
        txq.push_back('{F012, l, r});
        rxq.push_back('{R, l, r});
      end
      engq.push_back('{4'd1, l, NR - 1});
      txq.push_back('{H, l, NR - 1});
      if (l < NL - 1) rxq.push_back('{QI, l + 1, NR - 1});
    end
  endtask

  task automatic clear_sb();
    txq.delete(); rxq.delete(); engq.delete();
    done_cnt = 0; cnt_f012 = 0; cnt_h = 0; cnt_r = 0; cnt_qi = 0;
  endtask

  // Link and engine responder.
  int  eng_cnt = 0;
  bit  eng_pend = 0;
  always @(posedge clk) begin
    #1;
    if (auto_drv) begin
      abort = 1'b0;
      if (!rstb) begin
        eng_done = 0; tx_ready = 0; rx_valid = 0; eng_pend = 0;
      end else begin
        eng_done = 1'b0;
        if (eng_go) begin eng_pend = 1; eng_cnt = fast ? 0 : $urandom_range(0, 2); end
        if (eng_pend) begin
          if (eng_cnt == 0) begin eng_done = 1'b1; eng_pend = 0; end
          else eng_cnt--;
        end
        tx_ready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        rx_valid = rx_req && (fast || $urandom_range(0, 2) == 0);
        if (bp_arm && tx_valid && layer == 1 && round == 3 && !eng_is_h) begin
          tx_ready = (bp_cnt >= 5);
          bp_cnt++;
        end
        if (abort_arm && rx_req && rx_cmd == R && layer == 2 && round == 4) begin
          abort = 1'b1; rx_valid = 1'b0; abort_arm = 0; abort_hit = 1;
        end
        if (rst_arm && tx_valid && layer == 1) begin
          rstb = 1'b0; tx_ready = 1'b0; eng_done = 1'b0; rx_valid = 1'b0;
          rst_arm = 0; rst_hit = 1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  bit prev_rst = 0, prev_abort = 0, prev_stall = 0, prev_hmid = 0;
  logic [3:0] prev_cmd, prev_round, prev_layer;
  always @(negedge clk) begin
    ev_t e;
    bit live;
    if (prev_rst)
      chk("reset_outs", {eng_go, eng_is_h, tx_valid, rx_req, rx_load, done, busy, err,
                         layer, round, tx_cmd, rx_cmd}, 32'd0);
    if (prev_abort)
      chk("abort_drop", {busy, done, tx_valid, rx_req, eng_go}, 32'd0);
    if (prev_stall) begin
      chk("stall_valid", tx_valid, 1'b1);
      chk("stall_cmd", tx_cmd, prev_cmd);
      chk("stall_round", round, prev_round);
    end
    if (prev_hmid) begin
      chk("qi_layer", layer, prev_layer + 4'd1);
      chk("qi_cmd", {rx_req, rx_cmd}, {1'b1, QI});
    end
    chk("idx_range", (int'(round) < NR) && (int'(layer) < NL), 1'b1);
    live = rstb && !abort;
    if (live && sb_en) begin
      if (eng_go) begin
        if (engq.size() == 0) chk("eng_unexpected", 1, 0);
        else begin
          e = engq.pop_front();
          chk("eng_is_h", eng_is_h, e.cmd[0]);
          chk("eng_layer", layer, e.lyr);
          chk("eng_round", round, e.rnd);
        end
      end
      if (tx_valid && tx_ready) begin
        if (tx_cmd == F012) cnt_f012++;
        if (tx_cmd == H) cnt_h++;
        if (txq.size() == 0) chk("tx_unexpected", 1, 0);
        else begin
          e = txq.pop_front();
          chk("tx_cmd", tx_cmd, e.cmd);
          chk("tx_layer", layer, e.lyr);
          chk("tx_round", round, e.rnd);
        end
      end
      if (rx_load) begin
        if (rx_cmd == R) cnt_r++;
        if (rx_cmd == QI) cnt_qi++;
        if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
        else begin
          e = rxq.pop_front();
          chk("rx_cmd", rx_cmd, e.cmd);
          chk("rx_layer", layer, e.lyr);
          chk("rx_round", round, e.rnd);
        end
      end
      if (done) done_cnt++;
    end
    prev_rst   = !rstb;
    prev_abort = rstb && abort;
    prev_stall = live && tx_valid && !tx_ready;
    prev_hmid  = live && tx_valid && tx_ready && tx_cmd == H && int'(layer) < NL - 1;
    prev_cmd   = tx_cmd;
    prev_round = round;
    prev_layer = layer;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_comp(input bit fst);
    int n;
    fast = fst;
    clear_sb();
    push_expected();
    pulse_start();
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); #1; n++; end
    chk("done_seen", done_cnt != 0, 1'b1);
    @(negedge clk); #1;
    chk("done_once", done_cnt, 1);
    chk("q_empty", txq.size() + rxq.size() + engq.size(), 0);
    chk("tot_f012", cnt_f012, NL * NR);
    chk("tot_h", cnt_h, NL);
    chk("tot_r", cnt_r, NL * NR);
    chk("tot_qi", cnt_qi, NL - 1);
    chk("post_idle", {busy, err}, 2'b00);
    chk("final_idx", {layer, round}, {4'(NL - 1), 4'(NR - 1)});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    auto_drv = 1;

    run_comp(1'b1);
    run_comp(1'b0);
    bp_arm = 1; bp_cnt = 0;
    run_comp(1'b0);
    bp_arm = 0;
    chk("bp_held", bp_cnt >= 6, 1'b1);

    // Abort in GET_R at layer 2 round 4, then a clean restart.
    clear_sb(); push_expected(); fast = 0; abort_arm = 1;
    pulse_start();
    n = 0;
    while (!abort_hit && n < 3000) begin @(negedge clk); #1; n++; end
    chk("abort_seen", abort_hit, 1'b1);
    repeat (2) @(negedge clk); #1;
    chk("abort_state", {busy, err, 4'(done_cnt)}, 6'd0);
    run_comp(1'b0);

    // Reset in SEND on layer 1.
    clear_sb(); push_expected(); rst_arm = 1;
    pulse_start();
    n = 0;
    while (!rst_hit && n < 3000) begin @(negedge clk); #1; n++; end
    chk("rst_seen", rst_hit, 1'b1);
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    run_comp(1'b0);

    // Spurious rx_valid during COMPUTE, driven by hand.
    auto_drv = 0; sb_en = 0;
    @(posedge clk); #1 eng_done = 0; tx_ready = 0; rx_valid = 0; abort = 0;
    pulse_start();
    chk("q0_req", {busy, rx_req, rx_cmd, layer, round}, {2'b11, Q0, 8'd0});
    rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    chk("compute_go", {eng_go, eng_is_h}, 2'b10);
    rx_valid = 1'b1;
    @(posedge clk); #1 rx_valid = 1'b0;
    chk("spur_err", {err, busy}, 2'b10);
    @(posedge clk); #1;
    chk("err_sticky", err, 1'b1);
    pulse_start();
    chk("err_clear", {err, busy, rx_cmd}, {2'b01, Q0});
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_idle", {busy, err}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
